clean_beats_nios2_ocimem_master: RTL and testbench

//  Downstream consumer of the JTAG debug module's sysclk-domain outputs (jdo, take_action_ocimem_*).

---
 rtl/clean_beats_nios2_ocimem_master_pkg.sv | 19 +
 rtl/clean_beats_nios2_ocimem_master_wdog.sv | 24 ++
 rtl/clean_beats_nios2_ocimem_master.sv | 100 ++++++++++
 tb/tb_clean_beats_nios2_ocimem_master.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/clean_beats_nios2_ocimem_master_pkg.sv
// Shared encodings for the OCI memory master: FSM states, jdo field positions, command decode.
package clean_beats_nios2_ocimem_master_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_READ, ST_WRITE, ST_DONE} state_t;
  typedef enum logic [1:0] {CMD_NONE, CMD_ADDR, CMD_WRITE, CMD_NEXT} cmd_t;

  localparam int         JDO_RDNOW   = 35;
  localparam int         JDO_AUTOINC = 34;
  localparam logic [3:0] BYTEEN_ALL  = 4'hF;

  // Coincident pulses resolve a > b > no_action; the losers are simply dropped.
  function automatic cmd_t pick_cmd(input logic a, input logic b, input logic n);
    if (a)      return CMD_ADDR;
    else if (b) return CMD_WRITE;
    else if (n) return CMD_NEXT;
    else        return CMD_NONE;
  endfunction

endpackage

// File: rtl/clean_beats_nios2_ocimem_master_wdog.sv
// Wait-state watchdog: cleared while idle, counts stalled cycles, flags the abort cycle.
module clean_beats_ocimem_wdog #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic count,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   cnt <= '0;
    else if (load)  cnt <= '0;
    else if (count) cnt <= cnt + CW'(1);
  end

  // The TIMEOUT_CYC-th stalled cycle is the last one the strobe is held.
  assign expire = count && (cnt == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/clean_beats_nios2_ocimem_master.sv
// Debug-memory Avalon master: turns JTAG ocimem commands into single read/write transfers.
module clean_beats_nios2_ocimem_master
  import clean_beats_nios2_ocimem_master_pkg::*;
#(
  parameter int ADDR_W      = 24,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic [ADDR_W-1:0] m_address,
  output logic              m_read,
  output logic              m_write,
  output logic [31:0]       m_writedata,
  output logic [3:0]        m_byteenable,
  input  logic [31:0]       m_readdata,
  input  logic              m_waitrequest
);
  state_t            state, state_nxt;
  cmd_t              cmd;
  logic [ADDR_W-1:0] mon_areg;
  logic              autoinc;
  logic              err;
  logic              xfer, expire, any_pulse;
  logic              unused_jdo;

  assign cmd        = pick_cmd(take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a);
  assign any_pulse  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign xfer       = (state == ST_READ) || (state == ST_WRITE);
  assign unused_jdo = ^{jdo[37:36], jdo[33:32]};

  clean_beats_ocimem_wdog #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state == ST_IDLE),
    .count   (xfer && m_waitrequest),
    .expire  (expire)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        case (cmd)
          CMD_ADDR:  if (jdo[JDO_RDNOW]) state_nxt = ST_READ;
          CMD_WRITE: state_nxt = ST_WRITE;
          CMD_NEXT:  state_nxt = ST_READ;
          default:   state_nxt = ST_IDLE;
        endcase
      end
      ST_READ, ST_WRITE: begin
        if (!m_waitrequest) state_nxt = ST_DONE;
        else if (expire)    state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      MonDReg  <= '0;
      mon_areg <= '0;
      autoinc  <= 1'b0;
      err      <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (cmd == CMD_ADDR) begin
        mon_areg <= {jdo[ADDR_W-1:2], 2'b00};
        autoinc  <= jdo[JDO_AUTOINC];
        err      <= 1'b0;
      end else if (cmd == CMD_WRITE) begin
        MonDReg <= jdo[31:0];
      end
    end else begin
      // Commands arriving mid-transfer are dropped but leave a sticky error.
      if (any_pulse || expire) err <= 1'b1;
      if (state == ST_READ && !m_waitrequest) MonDReg <= m_readdata;
      if (state == ST_DONE && autoinc) mon_areg <= mon_areg + ADDR_W'(4);
    end
  end

  assign m_read        = (state == ST_READ);
  assign m_write       = (state == ST_WRITE);
  assign monitor_ready = (state == ST_IDLE);
  assign monitor_error = err;
  assign m_address     = mon_areg;
  assign m_writedata   = MonDReg;
  assign m_byteenable  = BYTEEN_ALL;

endmodule

// File: tb/tb_clean_beats_nios2_ocimem_master.sv
// Randomized bench: transaction-level reference model feeds result/bus queues checked by monitors.
module tb_clean_beats_nios2_ocimem_master;
  localparam int AW = 24;
  localparam int TO = 8;
  localparam logic [AW-1:0] AMASK = 24'hFFFFFC;

  logic          clk = 1'b0, reset_n = 1'b0;
  logic [37:0]   jdo = '0;
  logic          ta_a = 1'b0, ta_b = 1'b0, tna = 1'b0;
  logic [31:0]   MonDReg;
  logic          monitor_ready, monitor_error;
  logic [AW-1:0] m_address;
  logic          m_read, m_write;
  logic [31:0]   m_writedata;
  logic [3:0]    m_byteenable;
  logic [31:0]   m_readdata = '0;
  logic          m_waitrequest = 1'b0;

  clean_beats_nios2_ocimem_master #(.ADDR_W(AW), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .jdo(jdo),
    .take_action_ocimem_a(ta_a), .take_action_ocimem_b(ta_b), .take_no_action_ocimem_a(tna),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_readdata(m_readdata), .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Slave memory contents, shared by slave and model
  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    if (a == 24'h001000) return 32'hDEADBEEF;
    return {a, 8'h5A} ^ 32'h13579BDF;
  endfunction

  typedef struct { logic [31:0] d; logic e; logic [AW-1:0] a; } res_t;
  typedef struct { logic [AW-1:0] a; logic we; logic [31:0] wd; } bus_t;
  res_t res_q[$];
  bus_t bus_q[$];

  logic [AW-1:0] ma = '0;
  logic [31:0]   md = '0;
  logic          me = 1'b0, mai = 1'b0;

  // Slave: stalls cur_wait cycles per transfer, checks each accepted beat
  int cur_wait = 0;
  int wcnt = 0;
  logic in_x = 1'b0;
  logic [AW-1:0] x_a;
  logic [31:0]   x_d;
  always @(negedge clk) begin
    if (reset_n && (m_read || m_write)) begin
      if (!in_x) begin
        in_x = 1'b1; wcnt = 0; x_a = m_address; x_d = m_writedata;
      end
      m_waitrequest = (wcnt < cur_wait);
      m_readdata    = rom(m_address);
      wcnt++;
      if (!m_waitrequest) begin
        chk("addr_stable", m_address, x_a);
        if (m_write) chk("wdata_stable", m_writedata, x_d);
        chk("byteenable", m_byteenable, 4'hF);
        if (bus_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL bus_unexpected: got beat at %0h want none", m_address);
        end else begin
          bus_t b;
          b = bus_q.pop_front();
          chk("bus_addr", m_address, b.a);
          chk("bus_dir", m_write, b.we);
          if (b.we) chk("bus_wdata", m_writedata, b.wd);
        end
      end
    end else begin
      in_x = 1'b0;
      m_waitrequest = 1'($urandom_range(0, 1));
      m_readdata = $urandom;
    end
  end

  // Result monitor: each rising monitor_ready closes one command
  logic prev_rdy = 1'b1;
  always @(negedge clk) begin
    if (!reset_n) prev_rdy = 1'b1;
    else begin
      if (monitor_ready && !prev_rdy) begin
        if (res_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL res_unexpected: got ready rise want none");
        end else begin
          res_t r;
          r = res_q.pop_front();
          chk("res_MonDReg", MonDReg, r.d);
          chk("res_error", monitor_error, r.e);
          chk("res_address", m_address, r.a);
        end
      end
      prev_rdy = monitor_ready;
    end
  end

  // kind: 0 ocimem_a, 1 ocimem_b, 2 no_action, 3 ocimem_a+ocimem_b; poke>0 fires no_action mid-transfer
  task automatic do_cmd(input int kind, input logic [37:0] j, input int w, input int poke);
    int xfer, lat, slen, exp_lat, exp_slen;
    bit ok;
    xfer = 0; lat = 0; slen = 0;
    @(negedge clk);
    cur_wait = w;
    jdo = j;
    ta_a = (kind == 0 || kind == 3);
    ta_b = (kind == 1 || kind == 3);
    tna  = (kind == 2);
    if (kind == 0 || kind == 3) begin
      ma = j[AW-1:0] & AMASK; mai = j[34]; me = 1'b0;
      xfer = j[35] ? 1 : 0;
    end else if (kind == 1) begin
      md = j[31:0]; xfer = 2;
    end else xfer = 1;
    ok = (w < TO);
    if (xfer != 0) begin
      if (poke > 0) me = 1'b1;
      if (ok) begin
        bus_q.push_back('{a: ma, we: (xfer == 2), wd: md});
        if (xfer == 1) md = rom(ma);
        if (mai) ma = (ma + 24'd4) & AMASK;
      end else me = 1'b1;
      res_q.push_back('{d: md, e: me, a: ma});
    end
    exp_lat  = (xfer == 0) ? 1 : (ok ? w + 3 : TO + 1);
    exp_slen = (xfer == 0) ? 0 : (ok ? w + 1 : TO);
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (k == 1) begin ta_a = 1'b0; ta_b = 1'b0; tna = 1'b0; end
      if (poke > 0 && k == poke) tna = 1'b1;
      if (poke > 0 && k == poke + 1) tna = 1'b0;
      if (m_read || m_write) slen++;
      if (monitor_ready) begin lat = k; break; end
    end
    tna = 1'b0;
    chk("ready_latency", lat, exp_lat);
    chk("strobe_cycles", slen, exp_slen);
    if (xfer == 0) begin
      chk("load_address", m_address, ma);
      chk("load_MonDReg", MonDReg, md);
      chk("load_error", monitor_error, me);
    end
  endtask

  function automatic logic [37:0] mk(input logic rd, input logic ai, input logic [31:0] v);
    return {2'b00, rd, ai, 2'b00, v};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_MonDReg", MonDReg, 32'h0);
    chk("rst_ready", monitor_ready, 1'b1);
    chk("rst_error", monitor_error, 1'b0);
    chk("rst_strobes", {m_read, m_write}, 2'b00);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_address", m_address, 24'h0);

    do_cmd(0, mk(1, 1, 32'h0000_1000), 0, 0);           // 0-wait autoinc read
    do_cmd(1, mk(0, 0, 32'h1234_5678), 5, 0);           // stalled write
    do_cmd(0, mk(1, 1, 32'h0000_2000), 100, 0);         // stuck slave -> timeout
    do_cmd(0, mk(0, 0, 32'h0000_3000), 0, 0);           // address load clears error
    do_cmd(2, mk(0, 0, 32'h0), 3, 1);                   // poke during read
    do_cmd(0, mk(1, 1, 32'h00FF_FFFC), 1, 0);           // wraps to 0
    do_cmd(3, mk(0, 0, 32'hCAFE_0040), 0, 0);           // a+b coincident
    do_cmd(2, mk(0, 0, 32'h0), 0, 0);

    for (int i = 0; i < 40; i++) begin
      int kind, w, poke;
      logic [37:0] j;
      kind = $urandom_range(0, 3);
      j = {$urandom, $urandom};
      w = $urandom_range(0, 9);
      poke = 0;
      if ((kind == 1 || kind == 2 || j[35]) && kind != 3 && $urandom_range(0, 4) == 0) poke = 1;
      if (kind == 3) j[35] = 1'b0;
      do_cmd(kind, j, w, poke);
    end

    // Reset while a write is stalled
    @(negedge clk);
    cur_wait = 1000;
    jdo = mk(0, 0, 32'hA5A5_5A5A);
    ta_b = 1'b1;
    @(negedge clk);
    ta_b = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_write", m_write, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_write", m_write, 1'b0);
    chk("async_rst_read", m_read, 1'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_MonDReg", MonDReg, 32'h0);
    chk("post_rst_address", m_address, 24'h0);
    chk("post_rst_ready", monitor_ready, 1'b1);
    chk("post_rst_error", monitor_error, 1'b0);
    chk("post_rst_strobes", {m_read, m_write}, 2'b00);
    chk("res_q_drained", res_q.size(), 0);
    chk("bus_q_drained", bus_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
